// File: rtl/uart_frame_parser_pkg.sv
// rtl/uart_frame_parser_pkg.sv - shared states, command codes, error codes and defaults for the frame parser
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CHK
    } state_t;

    localparam logic [7:0] HEADER = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_CMD_LEN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int DEF_TIMEOUT = 260_000;
    localparam int TIMER_W     = 24;

    typedef struct packed {
        logic       wren;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic       rd_req;
        logic [7:0] rd_addr;
        logic [7:0] rd_len;
        logic       frame_ok;
        logic       frame_err;
        logic [1:0] err_code;
    } out_t;

endpackage

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte input and RAM/read-sequencer outputs of the frame parser
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       wren;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    modport slave (
        input  rx_data, rx_done,
        output wren, waddr, wdata, rd_req, rd_addr, rd_len, frame_ok, frame_err, err_code
    );

    modport master (
        output rx_data, rx_done,
        input  wren, waddr, wdata, rd_req, rd_addr, rd_len, frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/uart_frame_parser_timer.sv
// rtl/uart_frame_parser_timer.sv - inter-byte timeout counter with clear, enable and expire
module frame_timer
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TIMER_W-1:0] count;

    // A clear in the expiry cycle suppresses the expiry: the arriving byte wins.
    assign expire = en && !clr && (count == TIMER_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr || !en || expire) begin
            count <= '0;
        end else begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - framed command parser turning UART bytes into RAM writes and read requests
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                clk,
    input logic                rst,
    uart_frame_parser_if.slave bus
);

    state_t     state_q, state_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       is_rd_q, is_rd_d;
    out_t       out_q, out_d;
    logic       expire;

    frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.rx_done),
        .en     (state_q != ST_HUNT),
        .expire (expire)
    );

    always_comb begin
        state_d         = state_q;
        chk_d           = chk_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        is_rd_d         = is_rd_q;
        out_d           = out_q;
        out_d.wren      = 1'b0;
        out_d.rd_req    = 1'b0;
        out_d.frame_ok  = 1'b0;
        out_d.frame_err = 1'b0;

        if (expire) begin
            out_d.frame_err = 1'b1;
            out_d.err_code  = ERR_TIMEOUT;
            state_d         = ST_HUNT;
        end else if (bus.rx_done) begin
            case (state_q)
                ST_HUNT: begin
                    if (bus.rx_data == HEADER) begin
                        chk_d          = 8'h00;
                        out_d.err_code = ERR_NONE;
                        state_d        = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
                        is_rd_d = (bus.rx_data == CMD_RD);
                        chk_d   = bus.rx_data;
                        state_d = ST_ADDR;
                    end else begin
                        out_d.frame_err = 1'b1;
                        out_d.err_code  = ERR_CMD_LEN;
                        state_d         = ST_HUNT;
                    end
                end
                ST_ADDR: begin
                    addr_d  = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (bus.rx_data == 8'h00) begin
                        out_d.frame_err = 1'b1;
                        out_d.err_code  = ERR_CMD_LEN;
                        state_d         = ST_HUNT;
                    end else begin
                        cnt_d   = bus.rx_data;
                        chk_d   = chk_q ^ bus.rx_data;
                        state_d = is_rd_q ? ST_CHK : ST_DATA;
                    end
                end
                ST_DATA: begin
                    out_d.wren  = 1'b1;
                    out_d.waddr = addr_q;
                    out_d.wdata = bus.rx_data;
                    addr_d      = addr_q + 8'd1;
                    cnt_d       = cnt_q - 8'd1;
                    chk_d       = chk_q ^ bus.rx_data;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    // For reads addr/cnt still hold the untouched ADDR and LEN fields.
                    if (bus.rx_data == chk_q) begin
                        out_d.frame_ok = 1'b1;
                        if (is_rd_q) begin
                            out_d.rd_req  = 1'b1;
                            out_d.rd_addr = addr_q;
                            out_d.rd_len  = cnt_q;
                        end
                    end else begin
                        out_d.frame_err = 1'b1;
                        out_d.err_code  = ERR_CHK;
                    end
                    state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HUNT;
            chk_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            is_rd_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            out_q   <= out_d;
        end
    end

    assign bus.wren      = out_q.wren;
    assign bus.waddr     = out_q.waddr;
    assign bus.wdata     = out_q.wdata;
    assign bus.rd_req    = out_q.rd_req;
    assign bus.rd_addr   = out_q.rd_addr;
    assign bus.rd_len    = out_q.rd_len;
    assign bus.frame_ok  = out_q.frame_ok;
    assign bus.frame_err = out_q.frame_err;
    assign bus.err_code  = out_q.err_code;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed and randomized frame stimulus checked against a stream-level model
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_frame_parser_if bus();

    uart_frame_parser #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [1:0]  code;
    } ev_t;

    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_OK  = 2'd1;
    localparam logic [1:0] EV_RD  = 2'd2;
    localparam logic [1:0] EV_ERR = 2'd3;

    ev_t        mon_q[$];
    ev_t        exp_q[$];
    logic [7:0] rb[$];
    int         rc[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [1:0] k, input int c, input logic [7:0] a,
                               input logic [7:0] d, input logic [1:0] code);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.a    = a;
        e.d    = d;
        e.code = code;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.wren)      mon_q.push_back(mk(EV_WR, cyc, bus.waddr, bus.wdata, 2'd0));
            if (bus.frame_ok)  mon_q.push_back(mk(EV_OK, cyc, 8'd0, 8'd0, bus.err_code));
            if (bus.rd_req)    mon_q.push_back(mk(EV_RD, cyc, bus.rd_addr, bus.rd_len, 2'd0));
            if (bus.frame_err) mon_q.push_back(mk(EV_ERR, cyc, 8'd0, 8'd0, bus.err_code));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data = v;
        bus.rx_done = 1'b1;
        rb.push_back(v);
        rc.push_back(cyc);
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[k]) send(s[k], 0);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] s[$]);
        logic [7:0] x = 8'h00;
        for (int k = 1; k < s.size(); k++) x ^= s[k];
        return x;
    endfunction

    // Next in-frame byte, unless the gap from the previous one outlasts the timeout.
    function automatic bit adv(inout int i);
        if (i + 1 < rb.size() && rc[i+1] <= rc[i] + TMO) begin
            i++;
            return 1'b1;
        end
        exp_q.push_back(mk(EV_ERR, rc[i] + TMO + 1, 8'd0, 8'd0, ERR_TIMEOUT));
        i++;
        return 1'b0;
    endfunction

    task automatic run_model();
        int         i = 0;
        logic [7:0] cmd, addr, len, chk;
        bit         alive;
        while (i < rb.size()) begin
            if (rb[i] != HEADER) begin i++; continue; end
            if (!adv(i)) continue;
            cmd = rb[i];
            chk = cmd;
            if (cmd != CMD_WR && cmd != CMD_RD) begin
                exp_q.push_back(mk(EV_ERR, rc[i] + 1, 8'd0, 8'd0, ERR_CMD_LEN));
                i++;
                continue;
            end
            if (!adv(i)) continue;
            addr = rb[i];
            chk ^= addr;
            if (!adv(i)) continue;
            len = rb[i];
            chk ^= len;
            if (len == 8'd0) begin
                exp_q.push_back(mk(EV_ERR, rc[i] + 1, 8'd0, 8'd0, ERR_CMD_LEN));
                i++;
                continue;
            end
            alive = 1'b1;
            if (cmd == CMD_WR) begin
                for (int k = 0; k < int'(len) && alive; k++) begin
                    if (!adv(i)) alive = 1'b0;
                    else begin
                        exp_q.push_back(mk(EV_WR, rc[i] + 1, addr + 8'(k), rb[i], 2'd0));
                        chk ^= rb[i];
                    end
                end
            end
            if (!alive) continue;
            if (!adv(i)) continue;
            if (rb[i] == chk) begin
                exp_q.push_back(mk(EV_OK, rc[i] + 1, 8'd0, 8'd0, ERR_NONE));
                if (cmd == CMD_RD) exp_q.push_back(mk(EV_RD, rc[i] + 1, addr, len, 2'd0));
            end else begin
                exp_q.push_back(mk(EV_ERR, rc[i] + 1, 8'd0, 8'd0, ERR_CHK));
            end
            i++;
        end
    endtask

    task automatic clear_all();
        mon_q.delete();
        exp_q.delete();
        rb.delete();
        rc.delete();
    endtask

    task automatic end_session(input string name);
        repeat (TMO + 10) @(negedge clk);
        run_model();
        check($sformatf("%s_count", name), 64'(mon_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < mon_q.size() && k < exp_q.size(); k++)
            check($sformatf("%s_ev%0d", name, k), 64'(mon_q[k]), 64'(exp_q[k]));
        clear_all();
    endtask

    task automatic rand_frame();
        logic [7:0] f[$];
        int         kind = $urandom_range(0, 5);
        int         len;
        if ($urandom_range(0, 2) == 0) f.push_back(8'($urandom));
        f.push_back(HEADER);
        case (kind)
            1: begin
                f.push_back(CMD_RD);
                f.push_back(8'($urandom));
                f.push_back(8'($urandom_range(1, 255)));
            end
            3: f.push_back(8'($urandom_range(3, 255)));
            4: begin
                f.push_back(CMD_WR);
                f.push_back(8'($urandom));
                f.push_back(8'h00);
            end
            default: begin
                len = $urandom_range(1, 6);
                f.push_back(CMD_WR);
                f.push_back(8'($urandom));
                f.push_back(8'(len));
                for (int k = 0; k < len; k++) f.push_back(8'($urandom));
            end
        endcase
        if (kind != 3 && kind != 4) begin
            if (f[0] == HEADER) f.push_back(xsum(f));
            else begin
                f.push_back(8'h00);
                f[f.size()-1] = xsum(f[1:f.size()-2]);
            end
            if (kind == 5) f[f.size()-1] = f[f.size()-1] ^ 8'(1 << $urandom_range(0, 7));
        end
        foreach (f[k])
            send(f[k], ($urandom_range(0, 19) == 0) ? TMO - 1 + $urandom_range(0, 2)
                                                    : $urandom_range(0, 2));
    endtask

    logic [7:0] f[$];
    logic [63:0] outs;

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.wren, bus.waddr, bus.wdata, bus.rd_req, bus.rd_addr, bus.rd_len,
                bus.frame_ok, bus.frame_err, bus.err_code};
        check("reset_outputs", outs, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        f = '{8'hA5, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
        f.push_back(xsum(f));
        send_seq(f);
        end_session("write3");
        check("write3_errcode", 64'(bus.err_code), 64'(ERR_NONE));

        f = '{8'hA5, 8'h02, 8'h40, 8'h08, 8'h4A};
        send_seq(f);
        end_session("read");
        check("read_rd_addr", 64'(bus.rd_addr), 64'h40);
        check("read_rd_len", 64'(bus.rd_len), 64'h08);

        f = '{8'hA5, 8'h01, 8'hFE, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_seq(f);
        end_session("badchk_wrap");
        check("badchk_errcode", 64'(bus.err_code), 64'(ERR_CHK));

        f = '{8'hA5, 8'h07};
        send_seq(f);
        end_session("badcmd");
        check("badcmd_errcode", 64'(bus.err_code), 64'(ERR_CMD_LEN));

        f = '{8'hA5, 8'h01, 8'h00, 8'h00};
        send_seq(f);
        send(8'hA5, 0);
        check("errcode_cleared_on_header", 64'(bus.err_code), 64'(ERR_NONE));
        f = '{8'hA5, 8'h01, 8'h05, 8'h02, 8'hA5, 8'h5A};
        f.push_back(xsum(f));
        f = f[1:$];
        send_seq(f);
        end_session("zerolen_then_good");

        f = '{8'hA5, 8'h01, 8'h20};
        send_seq(f);
        end_session("timeout");
        check("timeout_errcode", 64'(bus.err_code), 64'(ERR_TIMEOUT));

        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h33, 0);
        send(8'h05, TMO - 1);
        send(8'h02 ^ 8'h33 ^ 8'h05, 0);
        end_session("coincident");

        send_seq('{8'hA5, 8'h01, 8'h50, 8'h05, 8'hAA});
        check("pre_reset_wren", 64'(bus.wren), 64'd1);
        #1 rst = 1'b0;
        #1;
        outs = {bus.wren, bus.waddr, bus.wdata, bus.rd_req, bus.rd_addr, bus.rd_len,
                bus.frame_ok, bus.frame_err, bus.err_code};
        check("midframe_reset_outputs", outs, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_all();
        @(negedge clk);
        f = '{8'hA5, 8'h01, 8'h60, 8'h02, 8'h77, 8'h88};
        f.push_back(xsum(f));
        send_seq(f);
        end_session("after_reset");

        for (int s = 0; s < 25; s++) begin
            repeat ($urandom_range(1, 3)) rand_frame();
            end_session($sformatf("rand%0d", s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
